// File: rtl/mem_port_arbiter_if.sv
// Host loader bus: ownership request/grant, transfer handshake and read-back.
// The master is the host side and the slave is the arbiter side.
interface mem_port_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              ext_req;
    logic              ext_gnt;
    logic              ext_valid;
    logic              ext_ready;
    logic              ext_we;
    logic [2:0]        ext_size;
    logic              ext_incr;
    logic              ext_addr_ld;
    logic [ADDR_W-1:0] ext_addr;
    logic [DATA_W-1:0] ext_wdata;
    logic [DATA_W-1:0] ext_rdata;
    logic              ext_rvalid;
    logic              ext_err;
    logic [CNT_W-1:0]  ext_count;

    modport master (
        output ext_req, ext_valid, ext_we, ext_size, ext_incr, ext_addr_ld, ext_addr, ext_wdata,
        input  ext_gnt, ext_ready, ext_rdata, ext_rvalid, ext_err, ext_count
    );

    modport slave (
        input  ext_req, ext_valid, ext_we, ext_size, ext_incr, ext_addr_ld, ext_addr, ext_wdata,
        output ext_gnt, ext_ready, ext_rdata, ext_rvalid, ext_err, ext_count
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares the single data-memory port between the CPU and a host loader using
// a four-state ownership handshake, burst addressing and size/alignment checks.
module mem_port_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              cpu_we,
    input  logic [2:0]        cpu_size,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_hold,

    mem_port_arbiter_if.slave hostBus,

    output logic              mem_we,
    output logic [2:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        StCpu,
        StHandover,
        StExt,
        StReturn
    } arbStateT;

    arbStateT          state;
    arbStateT          nextState;

    logic              accept;
    logic              sizeBad;
    logic              misaligned;
    logic              xferGood;
    logic              xferBad;
    logic              goodRead;
    logic [ADDR_W-1:0] addrCnt;
    logic [ADDR_W-1:0] effAddr;
    logic [ADDR_W-1:0] addrStep;

    // Acceptance depends on state only through the register, never on ext_ready.
    always_comb begin
        accept     = hostBus.ext_valid && (state == StExt);
        effAddr    = hostBus.ext_incr ? addrCnt : hostBus.ext_addr;
        sizeBad    = 1'b0;
        misaligned = 1'b0;
        addrStep   = '0;
        case (hostBus.ext_size)
            3'b000: addrStep = ADDR_W'(1);
            3'b001: begin
                addrStep   = ADDR_W'(2);
                misaligned = effAddr[0];
            end
            3'b010: begin
                addrStep   = ADDR_W'(4);
                misaligned = |effAddr[1:0];
            end
            default: sizeBad = 1'b1;
        endcase
        xferGood = accept && !sizeBad && !misaligned;
        xferBad  = accept && (sizeBad || misaligned);
        goodRead = xferGood && !hostBus.ext_we;
    end

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= StCpu;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        case (state)
            StCpu:      if (hostBus.ext_req) nextState = StHandover;
            StHandover: nextState = StExt;
            StExt:      if (!hostBus.ext_req && !goodRead) nextState = StReturn;
            StReturn:   nextState = StCpu;
            default:    nextState = StCpu;
        endcase
    end

    // NOTE: every output gets a default first so no branch leaves one unassigned and infers a latch.
    always_comb begin
        cpu_hold          = (state != StCpu);
        hostBus.ext_gnt   = (state == StExt);
        hostBus.ext_ready = (state == StExt);
        mem_we            = 1'b0;
        mem_size          = cpu_size;
        mem_addr          = cpu_addr;
        mem_wdata         = cpu_wdata;
        case (state)
            StCpu: mem_we = cpu_we;
            StExt: begin
                mem_we    = xferGood && hostBus.ext_we;
                mem_size  = hostBus.ext_size;
                mem_addr  = effAddr;
                mem_wdata = hostBus.ext_wdata;
            end
            default: ;
        endcase
    end

    assign cpu_rdata = mem_rdata;

    // A load on the same cycle as an incrementing transfer overrides the advance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addrCnt            <= '0;
            hostBus.ext_rdata  <= '0;
            hostBus.ext_rvalid <= 1'b0;
            hostBus.ext_err    <= 1'b0;
            hostBus.ext_count  <= '0;
        end else begin
            hostBus.ext_rvalid <= goodRead;
            hostBus.ext_err    <= xferBad;
            if (goodRead) hostBus.ext_rdata <= mem_rdata;

            if (hostBus.ext_addr_ld)              addrCnt <= hostBus.ext_addr;
            else if (xferGood && hostBus.ext_incr) addrCnt <= addrCnt + addrStep;

            if (state == StHandover)
                hostBus.ext_count <= '0;
            else if (xferGood && (hostBus.ext_count != '1))
                hostBus.ext_count <= hostBus.ext_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized self-checking bench for mem_port_arbiter: a byte-array memory stands
// in for data_mem and a transaction-level model predicts every host response.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_we;
    logic [2:0]  cpu_size;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_hold;
    logic        mem_we;
    logic [2:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    mem_port_arbiter_if host ();

    mem_port_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_we    (cpu_we),
        .cpu_size  (cpu_size),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_hold  (cpu_hold),
        .hostBus   (host.slave),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    // 4 KiB data memory driven by the DUT port (address bits above 11 ignored).
    logic [7:0] tbMem  [0:4095];
    logic [7:0] refMem [0:4095];

    always @(posedge clk) begin
        if (mem_we) begin
            tbMem[mem_addr[11:0]] <= mem_wdata[7:0];
            if (mem_size == 3'd1 || mem_size == 3'd2)
                tbMem[12'(mem_addr[11:0] + 12'd1)] <= mem_wdata[15:8];
            if (mem_size == 3'd2) begin
                tbMem[12'(mem_addr[11:0] + 12'd2)] <= mem_wdata[23:16];
                tbMem[12'(mem_addr[11:0] + 12'd3)] <= mem_wdata[31:24];
            end
        end
    end

    always_comb begin
        mem_rdata = {tbMem[{mem_addr[11:2], 2'b11}], tbMem[{mem_addr[11:2], 2'b10}],
                     tbMem[{mem_addr[11:2], 2'b01}], tbMem[{mem_addr[11:2], 2'b00}]};
    end

    int nChecks = 0;
    int nFails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] tbWord(input logic [31:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {tbMem[b + 12'd3], tbMem[b + 12'd2], tbMem[b + 12'd1], tbMem[b]};
    endfunction

    function automatic logic [31:0] refWord(input logic [31:0] a);
        logic [11:0] b;
        b = {a[11:2], 2'b00};
        return {refMem[b + 12'd3], refMem[b + 12'd2], refMem[b + 12'd1], refMem[b]};
    endfunction

    task automatic refWrite(input logic [31:0] a, input logic [2:0] size, input logic [31:0] d);
        logic [11:0] b;
        b = a[11:0];
        refMem[b] = d[7:0];
        if (size == 3'd1 || size == 3'd2) refMem[b + 12'd1] = d[15:8];
        if (size == 3'd2) begin
            refMem[b + 12'd2] = d[23:16];
            refMem[b + 12'd3] = d[31:24];
        end
    endtask

    // Transaction-level model of the host side.
    logic        modelGnt   = 1'b0;
    logic [31:0] modelCnt   = '0;
    int          modelCount = 0;
    logic [31:0] expRdata   = '0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One host cycle: drive, check the combinational port, clock, check the registered response.
    task automatic hostCycle(input logic valid, input logic we, input logic [2:0] size,
                             input logic incr, input logic ld, input logic [31:0] addr,
                             input logic [31:0] wdata);
        logic [31:0] eff;
        logic        acc;
        logic        bad;
        host.ext_valid   = valid;
        host.ext_we      = we;
        host.ext_size    = size;
        host.ext_incr    = incr;
        host.ext_addr_ld = ld;
        host.ext_addr    = addr;
        host.ext_wdata   = wdata;
        acc = valid && modelGnt;
        eff = incr ? modelCnt : addr;
        bad = (size > 3'd2) || (size == 3'd1 && eff[0]) || (size == 3'd2 && eff[1:0] != 2'b00);
        #1;
        check("ext_ready", 32'(host.ext_ready), 32'(modelGnt));
        check("mem_we", 32'(mem_we), 32'(acc && we && !bad));
        if (acc && we && !bad) check("mem_addr", mem_addr, eff);
        tick();
        if (acc && !bad) begin
            if (we) refWrite(eff, size, wdata);
            else    expRdata = refWord(eff);
            if (modelCount < 65535) modelCount++;
            if (incr) modelCnt = modelCnt + (32'd1 << size);
        end
        if (ld) modelCnt = addr;
        check("ext_err", 32'(host.ext_err), 32'(acc && bad));
        check("ext_rvalid", 32'(host.ext_rvalid), 32'(acc && !bad && !we));
        if (acc && !bad && !we) check("ext_rdata", host.ext_rdata, expRdata);
        check("ext_count", 32'(host.ext_count), 32'(modelCount));
        host.ext_valid   = 1'b0;
        host.ext_addr_ld = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0] rSize;
        logic [31:0] rAddr;
        logic        rLd;
        for (int i = 0; i < 4096; i++) begin
            tbMem[i]  = 8'h00;
            refMem[i] = 8'h00;
        end
        reset = 1'b1;
        cpu_we = 1'b0; cpu_size = 3'd2; cpu_addr = '0; cpu_wdata = '0;
        host.ext_req = 1'b0; host.ext_valid = 1'b0; host.ext_we = 1'b0; host.ext_size = 3'd2;
        host.ext_incr = 1'b0; host.ext_addr_ld = 1'b0; host.ext_addr = '0; host.ext_wdata = '0;

        // Reset state
        #2;
        check("rst cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst ext_gnt", 32'(host.ext_gnt), 32'd0);
        check("rst ext_ready", 32'(host.ext_ready), 32'd0);
        check("rst ext_rvalid", 32'(host.ext_rvalid), 32'd0);
        check("rst ext_err", 32'(host.ext_err), 32'd0);
        check("rst ext_rdata", host.ext_rdata, 32'd0);
        check("rst ext_count", 32'(host.ext_count), 32'd0);
        tick(); tick();
        reset = 1'b0;

        // CPU store passes straight through
        cpu_we = 1'b1; cpu_size = 3'd2; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
        #1;
        check("cpu mem_we", 32'(mem_we), 32'd1);
        check("cpu mem_addr", mem_addr, 32'h10);
        check("cpu mem_wdata", mem_wdata, 32'hDEADBEEF);
        check("cpu hold", 32'(cpu_hold), 32'd0);
        tick();
        cpu_we = 1'b0;
        refWrite(32'h10, 3'd2, 32'hDEADBEEF);
        #1;
        check("cpu word 0x10", tbWord(32'h10), refWord(32'h10));
        check("cpu_rdata", cpu_rdata, 32'hDEADBEEF);

        // Counter load outside EXT; host valid outside EXT is ignored
        hostCycle(1'b1, 1'b1, 3'd2, 1'b0, 1'b1, 32'h100, 32'h55);

        // Handover timing and CPU write suppression
        host.ext_req = 1'b1;
        #1;
        check("t hold", 32'(cpu_hold), 32'd0);
        tick();
        check("t+1 hold", 32'(cpu_hold), 32'd1);
        check("t+1 gnt", 32'(host.ext_gnt), 32'd0);
        cpu_we = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'hCAFEF00D;
        #1;
        check("t+1 mem_we", 32'(mem_we), 32'd0);
        tick();
        cpu_we = 1'b0;
        modelGnt = 1'b1;
        modelCount = 0;
        check("t+2 gnt", 32'(host.ext_gnt), 32'd1);
        check("word 0x20", tbWord(32'h20), refWord(32'h20));

        // Incrementing word burst from 0x100
        for (int i = 1; i <= 4; i++)
            hostCycle(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 32'h0, 32'(i));
        check("burst count", 32'(host.ext_count), 32'd4);
        check("burst 0x10C", tbWord(32'h10C), 32'd4);

        // Registered read-back
        hostCycle(1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 32'h104, 32'h0);
        check("readback 0x104", host.ext_rdata, 32'd2);

        // Rejected transfers: misaligned half and reserved size
        hostCycle(1'b1, 1'b1, 3'd1, 1'b0, 1'b0, 32'h101, 32'hFFFF);
        hostCycle(1'b1, 1'b1, 3'd3, 1'b0, 1'b0, 32'h200, 32'hFFFFFFFF);
        check("err word 0x200", tbWord(32'h200), 32'd0);
        check("err word 0x100", tbWord(32'h100), 32'd1);

        // Load coinciding with an incrementing transfer: old value used, load wins
        hostCycle(1'b1, 1'b1, 3'd2, 1'b1, 1'b1, 32'h500, 32'hA5A5A5A5);
        hostCycle(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 32'h0, 32'h5A5A5A5A);
        check("ld-win 0x500", tbWord(32'h500), 32'h5A5A5A5A);

        // Randomized host traffic, kept clear of 0x000..0x3FF
        for (int n = 0; n < 200; n++) begin
            rLd   = ($urandom_range(0, 7) == 0);
            rSize = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(3, 7));
            rAddr = rLd ? 32'h400 + 32'($urandom_range(0, 32'h700))
                        : 32'h400 + 32'($urandom_range(0, 32'hBFF));
            hostCycle(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), rSize,
                      1'($urandom_range(0, 1)), rLd, rAddr, $urandom);
        end

        // Drop ext_req with a read accepted: rvalid still delivered, then RETURN, then CPU
        host.ext_req = 1'b0;
        hostCycle(1'b1, 1'b0, 3'd2, 1'b0, 1'b0, 32'h104, 32'h0);
        check("drop rdata", host.ext_rdata, 32'd2);
        check("drop still gnt", 32'(host.ext_gnt), 32'd1);
        tick();
        check("return gnt", 32'(host.ext_gnt), 32'd0);
        check("return hold", 32'(cpu_hold), 32'd1);
        modelGnt = 1'b0;
        tick();
        check("cpu hold", 32'(cpu_hold), 32'd0);

        // Reset in the middle of a burst at 0x300
        hostCycle(1'b0, 1'b0, 3'd2, 1'b0, 1'b1, 32'h300, 32'h0);
        host.ext_req = 1'b1;
        tick(); tick();
        modelGnt = 1'b1;
        modelCount = 0;
        hostCycle(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 32'h0, 32'h11);
        hostCycle(1'b1, 1'b1, 3'd2, 1'b1, 1'b0, 32'h0, 32'h22);
        host.ext_valid = 1'b1; host.ext_we = 1'b1; host.ext_size = 3'd2;
        host.ext_incr = 1'b1; host.ext_wdata = 32'h33;
        #1;
        reset = 1'b1;
        #1;
        check("mid-rst gnt", 32'(host.ext_gnt), 32'd0);
        check("mid-rst hold", 32'(cpu_hold), 32'd0);
        check("mid-rst count", 32'(host.ext_count), 32'd0);
        check("mid-rst mem_we", 32'(mem_we), 32'd0);
        host.ext_req = 1'b0;
        host.ext_valid = 1'b0;
        tick();
        reset = 1'b0;
        modelGnt = 1'b0;
        modelCount = 0;
        modelCnt = '0;
        check("mid-rst 0x304", tbWord(32'h304), 32'h22);
        check("mid-rst 0x308", tbWord(32'h308), 32'd0);

        // Whole-memory sweep against the model
        for (int w = 0; w < 1024; w++)
            check("mem sweep", tbWord(32'(w * 4)), refWord(32'(w * 4)));

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
